// File: rtl/fifo9_pkg.sv
// Shared types for the 9-bit FIFO merge arbiter.
// Word layout is {rxc, data[7:0]}; rxc=0 marks an inter-frame gap.
package fifo9_pkg;

    localparam int WORD_W = 9;

    typedef struct packed {
        logic              rxc;
        logic [WORD_W-2:0] data;
    } word_t;

    localparam word_t GAP_WORD = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TERM = 2'd2
    } state_t;

endpackage

// File: rtl/fifo9_rr_arbiter_if.sv
// Bundle of four input FIFO read ports and one output FIFO write port.
// The master side is the arbiter; the slave side is the FIFO fabric.
interface fifo9_rr_arbiter_if;
    import fifo9_pkg::*;

    word_t [3:0] in_dout;
    logic  [3:0] in_empty;
    logic  [3:0] in_rd_en;
    word_t       out_din;
    logic        out_full;
    logic        out_wr_en;

    modport master (
        input  in_dout,
        input  in_empty,
        input  out_full,
        output in_rd_en,
        output out_din,
        output out_wr_en
    );

    modport slave (
        output in_dout,
        output in_empty,
        output out_full,
        input  in_rd_en,
        input  out_din,
        input  out_wr_en
    );

endinterface

// File: rtl/fifo9_rr_arbiter_rr_sel4.sv
// Four-way round-robin picker: first requester after 'last', wrapping.
// Purely combinational.
module rr_sel4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo9_rr_arbiter.sv
// Merges four 9-bit frame FIFOs into one stream, frame by frame,
// with round-robin port choice and a mid-frame starvation timeout.
module fifo9_rr_arbiter
    import fifo9_pkg::*;
#(
    parameter logic [15:0] Timeout = 16'd1024
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    fifo9_rr_arbiter_if.master         bus,
    output logic [1:0]                 grant,
    output logic                       busy,
    output logic [15:0]                timeout_cnt
);

    state_t      state_q, state_n;
    logic [1:0]  grant_q, grant_n;
    logic [1:0]  last_q, last_n;
    logic        started_q, started_n;
    logic        rd_q;
    logic [15:0] starv_q, starv_n;
    logic [15:0] tcnt_q, tcnt_n;

    logic [3:0]  rd_en;
    logic        wr_en;
    word_t       din;
    logic        term;

    logic        sel_found;
    logic [1:0]  sel_idx;
    word_t       cur_w;
    logic        cur_empty;

    assign cur_w     = bus.in_dout[grant_q];
    assign cur_empty = bus.in_empty[grant_q];

    rr_sel4 u_sel (
        .req   (~bus.in_empty),
        .last  (last_q),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            last_q    <= 2'd3;
            started_q <= 1'b0;
            rd_q      <= 1'b0;
            starv_q   <= 16'd0;
            tcnt_q    <= 16'd0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            last_q    <= last_n;
            started_q <= started_n;
            rd_q      <= |rd_en;
            starv_q   <= starv_n;
            tcnt_q    <= tcnt_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        last_n    = last_q;
        started_n = started_q;
        starv_n   = starv_q;
        tcnt_n    = tcnt_q;
        rd_en     = 4'b0000;
        wr_en     = 1'b0;
        din       = GAP_WORD;
        term      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_n   = XFER;
                    grant_n   = sel_idx;
                    started_n = 1'b0;
                    starv_n   = 16'd0;
                end
            end

            XFER: begin
                // Gap words ahead of the first frame byte are dropped.
                term = rd_q && !cur_w.rxc && started_q;
                if (rd_q && (cur_w.rxc || started_q)) begin
                    wr_en = 1'b1;
                    din   = cur_w;
                end
                if (rd_q && cur_w.rxc) begin
                    started_n = 1'b1;
                end
                if (term) begin
                    state_n = IDLE;
                    last_n  = grant_q;
                end else if (!cur_empty && !bus.out_full) begin
                    rd_en[grant_q] = 1'b1;
                    starv_n        = 16'd0;
                end else if (started_q && cur_empty) begin
                    starv_n = starv_q + 16'd1;
                    if (starv_n == Timeout) begin
                        state_n = TERM;
                    end
                end
            end

            TERM: begin
                if (!bus.out_full) begin
                    wr_en   = 1'b1;
                    din     = GAP_WORD;
                    state_n = IDLE;
                    last_n  = grant_q;
                    if (tcnt_q != 16'hFFFF) begin
                        tcnt_n = tcnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_rd_en  = rd_en;
    assign bus.out_wr_en = wr_en;
    assign bus.out_din   = din;
    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
    assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_fifo9_rr_arbiter.sv
// Bench for fifo9_rr_arbiter: FIFO models feed four ports, a scoreboard
// queue holds the expected merged stream.
module tb_fifo9_rr_arbiter;
    import fifo9_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] timeout_cnt;

    fifo9_rr_arbiter_if bus();

    fifo9_rr_arbiter #(.Timeout(16'd8)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .bus         (bus),
        .grant       (grant),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    word_t      fq[4][$];
    word_t      exp_q[$];
    logic [1:0] glog[$];
    int         gaps[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_data_cyc = 0;
    int         busy_falls = 0;
    logic       rd_prev = 1'b0;
    logic       busy_prev = 1'b0;
    word_t      mon_w;

    // Input FIFO models: data appears the cycle after the read enable.
    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bus.in_empty <= 4'hF;
            bus.in_dout  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.in_rd_en[i]) begin
                    if (fq[i].size() > 0) begin
                        bus.in_dout[i] <= fq[i].pop_front();
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL underflow port=%0d read while empty", i);
                    end
                end
                bus.in_empty[i] <= (fq[i].size() == 0);
            end
        end
    end

    // Output monitor and scoreboard.
    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst_n) begin
            if (bus.out_wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got=%h expected=none", bus.out_din);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (bus.out_din !== mon_w) begin
                        errors++;
                        $display("FAIL stream_word got=%h expected=%h", bus.out_din, mon_w);
                    end
                end
                if (bus.out_din.rxc) begin
                    checks++;
                    if (rd_prev !== 1'b1) begin
                        errors++;
                        $display("FAIL write_after_read got=%b expected=1", rd_prev);
                    end
                    last_data_cyc = cyc;
                end else begin
                    gaps.push_back(cyc - last_data_cyc);
                end
            end
            if (busy && !busy_prev) glog.push_back(grant);
            if (!busy && busy_prev) busy_falls++;
        end
        rd_prev   = |bus.in_rd_en;
        busy_prev = busy;
    end

    task automatic load(input int p, input int pre, input int n,
                        input int base, input int post, input bit term);
        word_t w;
        for (int i = 0; i < pre; i++) fq[p].push_back(GAP_WORD);
        for (int i = 0; i < n; i++) begin
            w.rxc  = 1'b1;
            w.data = 8'(base + i);
            fq[p].push_back(w);
            exp_q.push_back(w);
        end
        for (int i = 0; i < post; i++) fq[p].push_back(GAP_WORD);
        if (term) exp_q.push_back(GAP_WORD);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        bus.out_full = 1'b0;
        sys_rst_n    = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (bus.in_rd_en !== 4'h0 || bus.out_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_enables got=%h/%b expected=0/0", bus.in_rd_en, bus.out_wr_en);
        end
        checks++;
        if (bus.out_din !== 9'h000 || busy !== 1'b0 || grant !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%h/%b/%0d expected=0/0/0", bus.out_din, busy, grant);
        end
        checks++;
        if (timeout_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_tcnt got=%0d expected=0", timeout_cnt);
        end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || bus.in_rd_en !== 4'h0) begin
            errors++;
            $display("FAIL idle_no_req got=%b/%h expected=0/0", busy, bus.in_rd_en);
        end
    endtask

    task automatic test_all_ports();
        bit ok;
        glog.delete();
        for (int p = 0; p < 4; p++) load(p, 0, 64, p * 64, 1, 1'b1);
        wait_drain(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL all_ports_drain left=%0d expected=0", exp_q.size());
        end
        checks++;
        if (glog.size() != 4) begin
            errors++;
            $display("FAIL all_ports_grants got=%0d expected=4", glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (glog[i] !== 2'(i)) begin
                    errors++;
                    $display("FAIL grant_order idx=%0d got=%0d expected=%0d", i, glog[i], i);
                end
            end
        end
    endtask

    task automatic test_single_port1();
        bit ok;
        int falls0;
        glog.delete();
        falls0 = busy_falls;
        load(1, 0, 60, 8'h10, 2, 1'b1);
        wait_drain(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL port1_drain left=%0d expected=0", exp_q.size());
        end
        checks++;
        if (busy_falls - falls0 < 1) begin
            errors++;
            $display("FAIL port1_busy_fall got=%0d expected>=1", busy_falls - falls0);
        end
        // Leftover gap word re-grants port 1, which then waits without timing out.
        repeat (20) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1 || grant !== 2'd1 || timeout_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pre_frame_hold got=%b/%0d/%0d expected=1/1/0", busy, grant, timeout_cnt);
        end
        load(1, 0, 5, 8'hA0, 1, 1'b1);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL port1_second left=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int k;
        glog.delete();
        load(3, 0, 30, 8'h40, 1, 1'b1);
        ok = 1'b0;
        k  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (bus.out_full && (|bus.in_rd_en)) begin
                checks++;
                errors++;
                $display("FAIL read_while_full got=%h expected=0", bus.in_rd_en);
            end
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            k++;
            if (k % 3 == 0) bus.out_full = ~bus.out_full;
        end
        bus.out_full = 1'b0;
        repeat (6) @(negedge sys_clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL backpressure_drain left=%0d expected=0", exp_q.size());
        end
        checks++;
        if (glog.size() < 1 || glog[0] !== 2'd3) begin
            errors++;
            $display("FAIL backpressure_grant got=%0d expected=3", glog.size() ? glog[0] : 9);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        glog.delete();
        gaps.delete();
        load(2, 0, 10, 8'h80, 0, 1'b1);
        load(3, 0, 4, 8'hC0, 1, 1'b1);
        wait_drain(500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_drain left=%0d expected=0", exp_q.size());
        end
        checks++;
        if (timeout_cnt !== 16'd1) begin
            errors++;
            $display("FAIL timeout_cnt got=%0d expected=1", timeout_cnt);
        end
        checks++;
        if (glog.size() != 2 || glog[0] !== 2'd2 || glog[1] !== 2'd3) begin
            errors++;
            $display("FAIL timeout_grants got=%0d entries expected=2,3", glog.size());
        end
        checks++;
        if (gaps.size() < 1 || gaps[0] != 8) begin
            errors++;
            $display("FAIL timeout_delay got=%0d expected=8", gaps.size() ? gaps[0] : -1);
        end
        load(2, 0, 5, 8'h8A, 1, 1'b1);
        wait_drain(200, ok);
        checks++;
        if (!ok || timeout_cnt !== 16'd1) begin
            errors++;
            $display("FAIL remainder got=%0d/%0d expected=0/1", exp_q.size(), timeout_cnt);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        load(0, 0, 40, 8'h20, 1, 1'b1);
        repeat (15) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_rd_en !== 4'h0 || bus.out_wr_en !== 1'b0 || bus.out_din !== 9'h000) begin
            errors++;
            $display("FAIL async_reset_io got=%h/%b/%h expected=0/0/0",
                     bus.in_rd_en, bus.out_wr_en, bus.out_din);
        end
        checks++;
        if (busy !== 1'b0 || timeout_cnt !== 16'd0 || grant !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_state got=%b/%0d/%0d expected=0/0/0",
                     busy, timeout_cnt, grant);
        end
        for (int i = 0; i < 4; i++) fq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        glog.delete();
        load(0, 2, 20, 8'h60, 1, 1'b1);
        load(1, 0, 6, 8'hE0, 1, 1'b1);
        wait_drain(500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL post_reset_drain left=%0d expected=0", exp_q.size());
        end
        checks++;
        if (glog.size() != 2 || glog[0] !== 2'd0 || glog[1] !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_grants got=%0d entries expected=0,1", glog.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_ports();
        test_single_port1();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
